// File: rtl/pin_align_pkg.sv
// pin_align_pkg -- shared types and helpers for the pin alignment controller.
// Holds the FSM state encoding, the phase index type and the circular
// phase-distance helper used by the lock monitor.
package pin_align_pkg;

  localparam int PHASES = 8;

  typedef logic [2:0] phase_t;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACQUIRE = 2'd1,
    ST_LOCKED  = 2'd2
  } state_t;

  // Shortest distance between two phases on the 8-position ring (0..4).
  function automatic phase_t circ_dist(input phase_t a, input phase_t b);
    phase_t diff_s;
    diff_s = a - b;
    if (diff_s > 3'd4) begin
      return 3'd0 - diff_s;
    end else begin
      return diff_s;
    end
  endfunction

endpackage

// File: rtl/pin_align_ctrl_hist.sv
// phase_hist -- 8-bin transition histogram with strobe counter and argmax.
// The argmax sees the bin values including the strobe being accepted this
// cycle, so the window result is available in the same cycle as the
// completing strobe; bins and counter clear on that cycle or on clr.
module phase_hist
  import pin_align_pkg::*;
#(
  parameter int WINDOW = 16
) (
  input  logic                     clk300,
  input  logic                     rst_n,
  input  logic                     clr,
  input  logic                     inc,
  input  phase_t                   ptime,
  output logic                     done,
  output phase_t                   max_phase,
  output logic [$clog2(WINDOW):0]  max_val
);

  localparam int CW = $clog2(WINDOW);
  localparam int BW = CW + 1;

  logic [BW-1:0] bin_r     [PHASES];
  logic [BW-1:0] bin_nxt_s [PHASES];
  logic [CW-1:0] cnt_r;

  // Bin values after accepting the current strobe.
  always_comb begin
    for (int i = 0; i < PHASES; i++) begin
      if (inc && (ptime == 3'(i))) begin
        bin_nxt_s[i] = bin_r[i] + BW'(1);
      end else begin
        bin_nxt_s[i] = bin_r[i];
      end
    end
  end

  // Largest bin; strict compare keeps the lowest index on ties.
  always_comb begin
    max_phase = 3'd0;
    max_val   = bin_nxt_s[0];
    for (int i = 1; i < PHASES; i++) begin
      if (bin_nxt_s[i] > max_val) begin
        max_phase = 3'(i);
        max_val   = bin_nxt_s[i];
      end else begin
        max_phase = max_phase;
        max_val   = max_val;
      end
    end
  end

  assign done = inc && (cnt_r == CW'(WINDOW - 1));

  // Histogram and strobe counter storage.
  always_ff @(posedge clk300 or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= '0;
      for (int i = 0; i < PHASES; i++) bin_r[i] <= '0;
    end else if (clr || done) begin
      cnt_r <= '0;
      for (int i = 0; i < PHASES; i++) bin_r[i] <= '0;
    end else if (inc) begin
      cnt_r <= cnt_r + CW'(1);
      for (int i = 0; i < PHASES; i++) bin_r[i] <= bin_nxt_s[i];
    end
  end

endmodule

// File: rtl/pin_align_ctrl.sv
// pin_align_ctrl -- eye-centre phase selection from captured transitions.
// ACQUIRE collects a histogram of transition phases; a dominant phase
// locks the sampling point half a UI away. LOCKED monitors new strobes and
// drops back to ACQUIRE after LOSS_LIMIT consecutive far-off strobes.
// Optional build macro PIN_ALIGN_TRACK_EN adds slow edge tracking while
// locked (8 consecutive one-step deviations on the same side move the edge).
module pin_align_ctrl
  import pin_align_pkg::*;
#(
  parameter int WINDOW     = 16,
  parameter int LOCK_TOL   = 1,
  parameter int LOSS_LIMIT = 4
) (
  input  logic       clk300,
  input  logic       rst_n,
  input  logic       enable,
  input  logic       str,
  input  logic [2:0] ptime,
  output logic [2:0] sel_phase,
  output logic       locked,
  output logic       lol,
  output logic [7:0] fail_cnt
);

  localparam int     BW  = $clog2(WINDOW) + 1;
  localparam int     MW  = $clog2(LOSS_LIMIT + 1);
  localparam phase_t TOL = phase_t'(LOCK_TOL);

  state_t        state_r, state_nxt_s;
  logic          str_acq_s, str_lock_s, hist_clr_s;
  logic          win_done_s, win_ok_s;
  phase_t        hist_phase_s;
  logic [BW-1:0] hist_max_s;
  phase_t        dist_s;
  logic          hit_s, loss_s;
  phase_t        edge_r, edge_nxt_s;
  logic [MW-1:0] miss_r, miss_nxt_s;
  phase_t        sel_r, sel_nxt_s;
  logic          locked_r, locked_nxt_s;
  logic          lol_r, lol_nxt_s;
  logic [7:0]    fail_r, fail_nxt_s;
`ifdef PIN_ALIGN_TRACK_EN
  logic [2:0]    run_cnt_r, run_cnt_nxt_s;
  logic          run_up_r, run_up_nxt_s;
  logic          up_s;
`endif

  // Disable dominates any coincident strobe.
  assign str_acq_s  = enable && str && (state_r == ST_ACQUIRE);
  assign str_lock_s = enable && str && (state_r == ST_LOCKED);
  assign hist_clr_s = (state_r != ST_ACQUIRE) || !enable;

  phase_hist #(.WINDOW(WINDOW)) u_hist (
    .clk300    (clk300),
    .rst_n     (rst_n),
    .clr       (hist_clr_s),
    .inc       (str_acq_s),
    .ptime     (ptime),
    .done      (win_done_s),
    .max_phase (hist_phase_s),
    .max_val   (hist_max_s)
  );

  assign win_ok_s = hist_max_s >= BW'(WINDOW / 2);
  assign dist_s   = circ_dist(ptime, edge_r);
  assign hit_s    = dist_s <= TOL;
  assign loss_s   = !hit_s && (miss_r == MW'(LOSS_LIMIT - 1));
`ifdef PIN_ALIGN_TRACK_EN
  assign up_s     = (ptime == (edge_r + 3'd1));
`endif

  // FSM state register.
  always_ff @(posedge clk300 or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    if (!enable) begin
      state_nxt_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE:    state_nxt_s = ST_ACQUIRE;
        ST_ACQUIRE: begin
          if (win_done_s && win_ok_s) state_nxt_s = ST_LOCKED;
          else                        state_nxt_s = ST_ACQUIRE;
        end
        ST_LOCKED: begin
          if (str_lock_s && loss_s) state_nxt_s = ST_ACQUIRE;
          else                      state_nxt_s = ST_LOCKED;
        end
        default:    state_nxt_s = ST_IDLE;
      endcase
    end
  end

  // Output and lock-monitor next values.
  always_comb begin
    edge_nxt_s   = edge_r;
    miss_nxt_s   = miss_r;
    sel_nxt_s    = sel_r;
    fail_nxt_s   = fail_r;
    lol_nxt_s    = 1'b0;
    locked_nxt_s = (state_nxt_s == ST_LOCKED);
`ifdef PIN_ALIGN_TRACK_EN
    run_cnt_nxt_s = 3'd0;
    run_up_nxt_s  = run_up_r;
`endif
    case (state_r)
      ST_IDLE: begin
        miss_nxt_s = '0;
      end
      ST_ACQUIRE: begin
        miss_nxt_s = '0;
        if (win_done_s && win_ok_s) begin
          edge_nxt_s = hist_phase_s;
          sel_nxt_s  = hist_phase_s + 3'd4;
        end else if (win_done_s && (fail_r != 8'hFF)) begin
          fail_nxt_s = fail_r + 8'd1;
        end else begin
          fail_nxt_s = fail_r;
        end
      end
      ST_LOCKED: begin
        // Sampling point trails the edge by one cycle when tracking moves it.
        sel_nxt_s = edge_r + 3'd4;
        if (str_lock_s && hit_s) begin
          miss_nxt_s = '0;
        end else if (str_lock_s && loss_s) begin
          miss_nxt_s = '0;
          lol_nxt_s  = 1'b1;
        end else if (str_lock_s) begin
          miss_nxt_s = miss_r + MW'(1);
        end else begin
          miss_nxt_s = miss_r;
        end
`ifdef PIN_ALIGN_TRACK_EN
        run_cnt_nxt_s = run_cnt_r;
        if (str_lock_s && (dist_s == 3'd1)) begin
          if ((run_cnt_r != 3'd0) && (up_s == run_up_r)) begin
            if (run_cnt_r == 3'd7) begin
              edge_nxt_s    = up_s ? (edge_r + 3'd1) : (edge_r - 3'd1);
              run_cnt_nxt_s = 3'd0;
            end else begin
              run_cnt_nxt_s = run_cnt_r + 3'd1;
            end
          end else begin
            run_cnt_nxt_s = 3'd1;
            run_up_nxt_s  = up_s;
          end
        end else if (str_lock_s) begin
          run_cnt_nxt_s = 3'd0;
        end else begin
          run_cnt_nxt_s = run_cnt_r;
        end
`endif
      end
      default: begin
        miss_nxt_s = '0;
      end
    endcase
  end

  // Registered outputs and lock-monitor state.
  always_ff @(posedge clk300 or negedge rst_n) begin
    if (!rst_n) begin
      edge_r   <= 3'd0;
      miss_r   <= '0;
      sel_r    <= 3'd4;
      locked_r <= 1'b0;
      lol_r    <= 1'b0;
      fail_r   <= 8'd0;
`ifdef PIN_ALIGN_TRACK_EN
      run_cnt_r <= 3'd0;
      run_up_r  <= 1'b0;
`endif
    end else begin
      edge_r   <= edge_nxt_s;
      miss_r   <= miss_nxt_s;
      sel_r    <= sel_nxt_s;
      locked_r <= locked_nxt_s;
      lol_r    <= lol_nxt_s;
      fail_r   <= fail_nxt_s;
`ifdef PIN_ALIGN_TRACK_EN
      run_cnt_r <= run_cnt_nxt_s;
      run_up_r  <= run_up_nxt_s;
`endif
    end
  end

  assign sel_phase = sel_r;
  assign locked    = locked_r;
  assign lol       = lol_r;
  assign fail_cnt  = fail_r;

endmodule
